// File: rtl/accel_seq_pkg.sv
// Shared types and constants for the multi-axis accelerometer sequencer.
// Holds the FSM state enum, register map, SPI flags, error codes, LED helper.
package accel_seq_pkg;

  typedef enum logic [3:0] {
    ST_WHOAMI_REQ,
    ST_WHOAMI_WAIT,
    ST_INIT_REQ,
    ST_INIT_WAIT,
    ST_POLL_WAIT,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_EMIT,
    ST_HALT
  } state_e;

  localparam logic [7:0] REG_WHO_AM_I = 8'h0F;
  localparam logic [7:0] REG_CTRL1    = 8'h20;
  localparam logic [7:0] REG_TEMP_CFG = 8'h1F;
  localparam logic [7:0] REG_CTRL4    = 8'h23;
  localparam logic [7:0] REG_OUT_X_L  = 8'h28;

  localparam logic [7:0] FLAG_READ    = 8'h80;
  localparam logic [7:0] FLAG_AUTOINC = 8'h40;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_WHOAMI  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [5:0] NBITS_16 = 6'd15;
  localparam logic [5:0] NBITS_24 = 6'd23;

  // Offset-binary top three bits of the high byte pick the lit LED.
  function automatic logic [7:0] led_bar(input logic [7:0] h);
    logic [7:0] s;
    s = h + 8'h80;
    return 8'h01 << s[7:5];
  endfunction

endpackage

// File: rtl/seq_spi_txn.sv
// One SPI request/ready handshake with a per-phase timeout counter.
// Ports: start_i/wait_i phase flags, spi_ready_i/miso in; request, accepted, done, timeout, rdata out.
module seq_spi_txn
  import accel_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        wait_i,
  input  logic        spi_ready_i,
  input  logic [31:0] spi_miso_data_i,
  output logic        spi_request_o,
  output logic        accepted_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] rdata_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          active;
  logic          limit;

  assign active     = start_i | wait_i;
  // Ready low only counts once our own request is on the wire.
  assign accepted_o = start_i & req_q & ~spi_ready_i;
  assign done_o     = wait_i & spi_ready_i;
  assign limit      = cnt_q >= CW'(TIMEOUT_CYCLES - 1);
  assign timeout_o  = active & limit & ~accepted_o & ~done_o;
  assign rdata_o    = spi_miso_data_i;

  assign spi_request_o = req_q;

  always_comb begin
    req_d = start_i & ~accepted_o & ~timeout_o;
    cnt_d = cnt_q + CW'(1);
    // Any phase change reloads the counter.
    if (!active || accepted_o || done_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      req_q <= req_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/accel_seq_multi.sv
// Accelerometer sequencer: WHO_AM_I check, init writes, paced multi-axis reads.
// Ports: clk_in/rst/enable; SPI master mosi/miso/nbits/request/ready; sample, status, LED outputs.
module accel_seq_multi
  import accel_seq_pkg::*;
#(
  parameter int         NUM_AXES       = 3,
  parameter int         SAMPLE_W       = 16,
  parameter logic [7:0] WHOAMI_VAL     = 8'h33,
  parameter int         WHOAMI_RETRIES = 4,
  parameter logic [3:0] ODR            = 4'h7,
  parameter int         TEMP_EN        = 1,
  parameter int         POLL_CYCLES    = 1000,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter int         LED_AXIS       = 0
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                enable,
  output logic [31:0]         spi_mosi_data,
  input  logic [31:0]         spi_miso_data,
  output logic [5:0]          spi_nbits,
  output logic                spi_request,
  input  logic                spi_ready,
  output logic                sample_valid,
  output logic [1:0]          sample_axis,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                busy,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [7:0]          led_out
);

  localparam int AW = $clog2(WHOAMI_RETRIES + 1);
  localparam int PW = $clog2(POLL_CYCLES + 2);

  localparam logic [2:0] AXIS_EN = {
    (NUM_AXES > 2), (NUM_AXES > 1), (NUM_AXES > 0)
  };
  localparam logic [7:0] TEMP_BYTE = (TEMP_EN != 0) ? 8'hC0 : 8'h00;

  state_e              state_q, state_d;
  logic [AW-1:0]       att_q, att_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          axis_q, axis_d;
  logic [PW-1:0]       poll_q, poll_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;
  logic [1:0]          saxis_q, saxis_d;
  logic [SAMPLE_W-1:0] sdata_q, sdata_d;
  logic [7:0]          led_q, led_d;
  logic [31:0]         mosi_q, mosi_d;
  logic [5:0]          nbits_q, nbits_d;

  logic        txn_start, txn_wait;
  logic        txn_acc, txn_done, txn_tmo;
  logic [31:0] txn_rdata;
  logic [15:0] init_word;
  logic [7:0]  rd_addr;
  logic [SAMPLE_W-1:0] smp_c;
  logic        unused_rdata;

  assign txn_start = state_q inside {ST_WHOAMI_REQ, ST_INIT_REQ, ST_READ_REQ};
  assign txn_wait  = state_q inside {ST_WHOAMI_WAIT, ST_INIT_WAIT, ST_READ_WAIT};

  seq_spi_txn #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_txn (
    .clk_i          (clk_in),
    .rst_i          (rst),
    .start_i        (txn_start),
    .wait_i         (txn_wait),
    .spi_ready_i    (spi_ready),
    .spi_miso_data_i(spi_miso_data),
    .spi_request_o  (spi_request),
    .accepted_o     (txn_acc),
    .done_o         (txn_done),
    .timeout_o      (txn_tmo),
    .rdata_o        (txn_rdata)
  );

  // miso[15:8] is OUT_L, miso[7:0] is OUT_H.
  if (SAMPLE_W == 16) begin : g_w16
    assign smp_c = {txn_rdata[7:0], txn_rdata[15:8]};
  end else begin : g_w8
    assign smp_c = txn_rdata[7:0];
  end

  assign unused_rdata = ^txn_rdata[31:8];

  always_comb begin
    unique case (idx_q)
      2'd0:    init_word = {REG_CTRL1, ODR, 1'b0, AXIS_EN};
      2'd1:    init_word = {REG_TEMP_CFG, TEMP_BYTE};
      default: init_word = {REG_CTRL4, 8'h88};
    endcase
  end

  assign rd_addr = FLAG_READ | FLAG_AUTOINC |
                   (REG_OUT_X_L + {5'd0, axis_q, 1'b0});

  always_comb begin
    state_d = state_q;
    att_d   = att_q;
    idx_d   = idx_q;
    axis_d  = axis_q;
    poll_d  = poll_q;
    err_d   = err_q;
    code_d  = code_q;
    saxis_d = saxis_q;
    sdata_d = sdata_q;
    led_d   = led_q;
    mosi_d  = mosi_q;
    nbits_d = nbits_q;
    unique case (state_q)
      ST_WHOAMI_REQ: begin
        mosi_d  = {16'h0, FLAG_READ | REG_WHO_AM_I, 8'h00};
        nbits_d = NBITS_16;
        if (txn_acc) state_d = ST_WHOAMI_WAIT;
      end
      ST_WHOAMI_WAIT: begin
        if (txn_done) begin
          if (txn_rdata[7:0] == WHOAMI_VAL) begin
            idx_d   = 2'd0;
            state_d = ST_INIT_REQ;
          end else if (att_q == AW'(WHOAMI_RETRIES - 1)) begin
            err_d   = 1'b1;
            code_d  = ERR_WHOAMI;
            state_d = ST_HALT;
          end else begin
            att_d   = att_q + AW'(1);
            state_d = ST_WHOAMI_REQ;
          end
        end
      end
      ST_INIT_REQ: begin
        mosi_d  = {16'h0, init_word};
        nbits_d = NBITS_16;
        if (txn_acc) state_d = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (txn_done) begin
          if (idx_q == 2'd2) begin
            poll_d  = '0;
            state_d = ST_POLL_WAIT;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_INIT_REQ;
          end
        end
      end
      ST_POLL_WAIT: begin
        if (poll_q != PW'(POLL_CYCLES)) begin
          poll_d = poll_q + PW'(1);
        end else if (enable) begin
          axis_d  = 2'd0;
          state_d = ST_READ_REQ;
        end
      end
      ST_READ_REQ: begin
        mosi_d  = {8'h00, rd_addr, 16'h0000};
        nbits_d = NBITS_24;
        if (txn_acc) state_d = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        // Load the sample registers so they show up during EMIT.
        if (txn_done) begin
          saxis_d = axis_q;
          sdata_d = smp_c;
          if (axis_q == 2'(LED_AXIS)) led_d = led_bar(txn_rdata[7:0]);
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (axis_q < 2'(NUM_AXES - 1)) begin
          axis_d  = axis_q + 2'd1;
          state_d = ST_READ_REQ;
        end else begin
          poll_d  = '0;
          state_d = ST_POLL_WAIT;
        end
      end
      ST_HALT: begin
      end
      default: state_d = ST_HALT;
    endcase
    if (txn_tmo) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_WHOAMI_REQ;
      att_q   <= '0;
      idx_q   <= 2'd0;
      axis_q  <= 2'd0;
      poll_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      saxis_q <= 2'd0;
      sdata_q <= '0;
      led_q   <= 8'hFF;
      mosi_q  <= 32'h0;
      nbits_q <= 6'd0;
    end else begin
      state_q <= state_d;
      att_q   <= att_d;
      idx_q   <= idx_d;
      axis_q  <= axis_d;
      poll_q  <= poll_d;
      err_q   <= err_d;
      code_q  <= code_d;
      saxis_q <= saxis_d;
      sdata_q <= sdata_d;
      led_q   <= led_d;
      mosi_q  <= mosi_d;
      nbits_q <= nbits_d;
    end
  end

  assign spi_mosi_data = mosi_q;
  assign spi_nbits     = nbits_q;
  assign sample_valid  = (state_q == ST_EMIT);
  assign sample_axis   = saxis_q;
  assign sample_data   = sdata_q;
  assign busy          = !(state_q inside {ST_POLL_WAIT, ST_HALT});
  assign err           = err_q;
  assign err_code      = code_q;
  assign led_out       = led_q;

endmodule

// File: tb/tb_accel_seq_multi.sv
// Directed bench for accel_seq_multi with a behavioural SPI master model.
// A second SAMPLE_W=8 instance shares all inputs and is checked alongside.
module tb_accel_seq_multi;

  localparam int POLL = 10;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable;
  logic        spi_ready = 1'b1;
  logic [31:0] spi_miso_data = 32'h0;
  logic [31:0] spi_mosi_data, mosi8;
  logic [5:0]  spi_nbits, nbits8;
  logic        spi_request, req8;
  logic        sample_valid, sv8;
  logic [1:0]  sample_axis, axis8;
  logic [15:0] sample_data;
  logic [7:0]  data8;
  logic        busy, busy8, err, err8;
  logic [1:0]  err_code, code8;
  logic [7:0]  led_out, led8;

  accel_seq_multi #(
    .NUM_AXES(3), .SAMPLE_W(16), .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .clk_in(clk), .rst(rst), .enable(enable),
    .spi_mosi_data(spi_mosi_data), .spi_miso_data(spi_miso_data),
    .spi_nbits(spi_nbits), .spi_request(spi_request), .spi_ready(spi_ready),
    .sample_valid(sample_valid), .sample_axis(sample_axis),
    .sample_data(sample_data), .busy(busy), .err(err),
    .err_code(err_code), .led_out(led_out)
  );

  accel_seq_multi #(
    .NUM_AXES(3), .SAMPLE_W(8), .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)
  ) u_dut8 (
    .clk_in(clk), .rst(rst), .enable(enable),
    .spi_mosi_data(mosi8), .spi_miso_data(spi_miso_data),
    .spi_nbits(nbits8), .spi_request(req8), .spi_ready(spi_ready),
    .sample_valid(sv8), .sample_axis(axis8),
    .sample_data(data8), .busy(busy8), .err(err8),
    .err_code(code8), .led_out(led8)
  );

  typedef struct packed {
    logic [31:0] mosi;
    logic [5:0]  nbits;
  } txn_t;

  typedef struct {
    logic [1:0]  axis;
    logic [15:0] d16;
    logic [7:0]  d8;
    logic [7:0]  led;
  } smp_t;

  typedef struct {
    logic [7:0]  l;
    logic [7:0]  h;
    logic [15:0] d;
    logic [7:0]  led;
  } vec_t;

  txn_t        txq[$];
  smp_t        sq[$];
  bit          stuck = 1'b0;
  logic [7:0]  who_resp = 8'h33;
  logic [7:0]  ax_l[3];
  logic [7:0]  ax_h[3];
  int          m_cnt = 0;
  bit          m_busy = 1'b0;
  logic [31:0] m_resp = 32'h0;
  int          applied = 0;
  int          miscompares = 0;

  function automatic logic [31:0] respond(input logic [31:0] m,
                                          input logic [5:0] nb);
    logic [1:0] a;
    if (nb == 6'd15 && m[15:8] == 8'h8F) return {24'h0, who_resp};
    if (nb == 6'd23) begin
      a = m[18:17];
      if (a != 2'd3) return {16'h0, ax_l[a], ax_h[a]};
    end
    return 32'h0;
  endfunction

  // SPI master model: drops ready after a request, answers 4 cycles later.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      m_busy = 1'b0;
      spi_ready = 1'b1;
      spi_miso_data = 32'h0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        spi_ready = 1'b1;
        spi_miso_data = m_resp;
        m_busy = 1'b0;
      end else begin
        m_cnt--;
      end
    end else if (spi_request && !stuck) begin
      txq.push_back('{mosi: spi_mosi_data, nbits: spi_nbits});
      m_resp = respond(spi_mosi_data, spi_nbits);
      spi_ready = 1'b0;
      m_cnt = 3;
      m_busy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (sample_valid === 1'b1)
      sq.push_back('{sample_axis, sample_data, data8, led_out});
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   spi_request, 0);
    check({tag, "_mosi"},  spi_mosi_data, 0);
    check({tag, "_nbits"}, spi_nbits, 0);
    check({tag, "_valid"}, sample_valid, 0);
    check({tag, "_axis"},  sample_axis, 0);
    check({tag, "_data"},  sample_data, 0);
    check({tag, "_data8"}, data8, 0);
    check({tag, "_err"},   {err, err_code}, 0);
    check({tag, "_led"},   led_out, 8'hFF);
    check({tag, "_busy"},  busy, 1);
  endtask

  initial begin
    vec_t        v[7];
    logic [15:0] init_exp[4];
    logic [15:0] y_exp, z_exp;
    bit          ok;
    int          n;
    int          bad;

    v[0] = '{8'h34, 8'h12, 16'h1234, 8'h10};
    v[1] = '{8'h00, 8'h80, 16'h8000, 8'h01};
    v[2] = '{8'hFF, 8'h7F, 16'h7FFF, 8'h80};
    v[3] = '{8'hAA, 8'h00, 16'h00AA, 8'h10};
    v[4] = '{8'h55, 8'hE0, 16'hE055, 8'h08};
    v[5] = '{8'h01, 8'hC0, 16'hC001, 8'h04};
    v[6] = '{8'h99, 8'hA0, 16'hA099, 8'h02};
    init_exp[0] = 16'h8F00;
    init_exp[1] = 16'h2077;
    init_exp[2] = 16'h1FC0;
    init_exp[3] = 16'h2388;
    ax_l[1] = 8'h22; ax_h[1] = 8'h11;
    ax_l[2] = 8'h44; ax_h[2] = 8'h33;
    y_exp = 16'h1122;
    z_exp = 16'h3344;

    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    rst = 1'b0;
    wait_idle(500, ok);
    check("init_idle", ok, 1);
    check("init_count", txq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < txq.size()) begin
        check("init_mosi", txq[i].mosi, {16'h0, init_exp[i]});
        check("init_nbits", txq[i].nbits, 15);
      end
    end
    check("init_err", {err, err_code}, 0);

    repeat (5000) @(negedge clk);
    check("idle_no_reads", txq.size(), 4);
    check("idle_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      ax_l[0] = v[i].l;
      ax_h[0] = v[i].h;
      txq.delete();
      sq.delete();
      enable = 1'b1;
      n = 0;
      while (spi_request !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("first_req_latency", (n <= POLL + 2), 1);
      n = 0;
      while (sq.size() == 0 && n < 300) begin
        @(negedge clk);
        n++;
      end
      enable = 1'b0;
      wait_idle(500, ok);
      check("round_idle", ok, 1);
      check("round_samples", sq.size(), 3);
      check("round_reads", txq.size(), 3);
      for (int a = 0; a < 3; a++) begin
        if (a < txq.size()) begin
          check("read_mosi", txq[a].mosi, {8'h00, 8'hE8 + 8'(2 * a), 16'h0});
          check("read_nbits", txq[a].nbits, 23);
        end
        if (a < sq.size()) begin
          check("smp_axis", sq[a].axis, a);
          check("smp_data16", sq[a].d16,
                (a == 0) ? v[i].d : (a == 1) ? y_exp : z_exp);
          check("smp_data8", sq[a].d8,
                (a == 0) ? v[i].h : (a == 1) ? ax_h[1] : ax_h[2]);
          check("smp_led", sq[a].led, v[i].led);
        end
      end
      check("hold_data", sample_data, z_exp);
      check("hold_valid", sample_valid, 0);
    end

    enable = 1'b1;
    n = 0;
    while (!(spi_request === 1'b1 && spi_nbits == 6'd23) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midrd_req_seen", n < 100, 1);
    n = 0;
    while (spi_request !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midrd_accepted", n < 50, 1);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrd");
    txq.delete();
    rst = 1'b0;
    n = 0;
    while (txq.size() == 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("restart_seen", txq.size() > 0, 1);
    if (txq.size() > 0) check("restart_whoami", txq[0].mosi, 32'h8F00);
    wait_idle(500, ok);
    check("restart_idle", ok, 1);

    rst = 1'b1;
    who_resp = 8'h00;
    repeat (2) @(negedge clk);
    txq.delete();
    rst = 1'b0;
    wait_idle(1000, ok);
    check("whoami_halt", ok, 1);
    check("whoami_err", {err, err_code}, {1'b1, 2'd1});
    check("whoami_count", txq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < txq.size()) check("whoami_mosi", txq[i].mosi, 32'h8F00);
    end
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (spi_request !== 1'b0) bad++;
    end
    check("whoami_req_quiet", bad, 0);
    check("whoami_count_after", txq.size(), 4);

    rst = 1'b1;
    who_resp = 8'h33;
    stuck = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (spi_request !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("tmo_req_seen", spi_request, 1);
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", (n <= 17), 1);
    check("tmo_code", err_code, 2);
    check("tmo_busy", busy, 0);
    @(negedge clk);
    check("tmo_req_low", spi_request, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
